result_sink: RTL and testbench

- Receive end of the accelerator write interface.
- Accepts 21-bit results presented on wrReq/wrData, buffers them in an internal FIFO and tracks batch boundaries signalled by wDone.
- Exposes a registered read port so a host or downstream stage can drain results at its own pace.
- Sits between the accelerator output and the host/memory side of the top-level design.

---
 rtl/result_sink.sv | 126 ++++++++++++
 tb/tb_result_sink.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_sink.sv
// result_sink: receive end of the accelerator write interface.
// Buffers results in a FIFO and reports batch boundaries.
module result_sink #(
    parameter int DATA_W = 21,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrReq,
    input  logic [DATA_W-1:0] wrData,
    input  logic              wDone,
    input  logic              rdReq,
    input  logic              clrErr,
    output logic [DATA_W-1:0] rdData,
    output logic              rdValid,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic              batchDone,
    output logic [CNT_W-1:0]  batchCount,
    output logic              overflow
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wrPtr;
    logic [AW-1:0]     rdPtr;
    logic [CNT_W-1:0]  batchCnt;
    state_t            state;

    logic doRd;
    logic doWr;
    logic drop;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // A pop frees the slot, so a write on full is still taken alongside it.
    assign doRd = rdReq && !empty;
    assign doWr = wrReq && (!full || doRd);
    assign drop = wrReq && full && !doRd;

    always_ff @(posedge clk) begin
        if (doWr) begin
            mem[wrPtr] <= wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            rdData  <= '0;
            rdValid <= 1'b0;
        end else begin
            rdValid <= doRd;
            if (doRd) begin
                rdData <= mem[rdPtr];
                rdPtr  <= rdPtr + 1'b1;
            end
            if (doWr) begin
                wrPtr <= wrPtr + 1'b1;
            end
            unique case ({doWr, doRd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clrErr) begin
            overflow <= 1'b0;
        end
    end

    // A word arriving with wDone closes into the finishing batch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            batchCnt   <= '0;
            batchDone  <= 1'b0;
            batchCount <= '0;
        end else begin
            batchDone <= 1'b0;
            if (wDone) begin
                batchDone  <= 1'b1;
                batchCount <= batchCnt + CNT_W'(doWr);
                batchCnt   <= '0;
                state      <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (doWr) begin
                            batchCnt <= CNT_W'(1);
                            state    <= COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (doWr) begin
                            batchCnt <= batchCnt + 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        batchCnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_result_sink.sv
// tb_result_sink: directed vectors for result_sink.
// Inputs change 1ns after posedge; outputs sampled there too.
module tb_result_sink;

    logic        clk;
    logic        rst;
    logic        wrReq;
    logic [20:0] wrData;
    logic        wDone;
    logic        rdReq;
    logic        clrErr;
    logic [20:0] rdData;
    logic        rdValid;
    logic        empty;
    logic        full;
    logic [4:0]  count;
    logic        batchDone;
    logic [4:0]  batchCount;
    logic        overflow;

    int nPass;
    int nChecks;

    logic [20:0] basicVals [3];

    result_sink dut (
        .clk        (clk),
        .rst        (rst),
        .wrReq      (wrReq),
        .wrData     (wrData),
        .wDone      (wDone),
        .rdReq      (rdReq),
        .clrErr     (clrErr),
        .rdData     (rdData),
        .rdValid    (rdValid),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .batchDone  (batchDone),
        .batchCount (batchCount),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            nPass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nPass   = 0;
        nChecks = 0;
        rst     = 1'b1;
        wrReq   = 1'b0;
        wrData  = '0;
        wDone   = 1'b0;
        rdReq   = 1'b0;
        clrErr  = 1'b0;
        basicVals[0] = 21'h00001;
        basicVals[1] = 21'h10000;
        basicVals[2] = 21'h1FFFF;
        tick();
        tick();
        rst = 1'b0;

        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_rdValid", 32'(rdValid), 32'd0);
        check("rst_rdData", 32'(rdData), 32'd0);
        check("rst_batchDone", 32'(batchDone), 32'd0);
        check("rst_batchCount", 32'(batchCount), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Basic: three writes, close batch, drain
        for (int i = 0; i < 3; i++) begin
            wrReq  = 1'b1;
            wrData = basicVals[i];
            tick();
            if (i == 0) check("wr_empty_lat", 32'(empty), 32'd0);
        end
        wrReq = 1'b0;
        wDone = 1'b1;
        tick();
        wDone = 1'b0;
        check("basic_batchDone", 32'(batchDone), 32'd1);
        check("basic_batchCount", 32'(batchCount), 32'd3);
        check("basic_count", 32'(count), 32'd3);
        tick();
        check("basic_bd_once", 32'(batchDone), 32'd0);
        for (int i = 0; i < 3; i++) begin
            rdReq = 1'b1;
            tick();
            check("basic_rdValid", 32'(rdValid), 32'd1);
            check("basic_rdData", 32'(rdData), 32'(basicVals[i]));
        end
        rdReq = 1'b0;
        tick();
        check("basic_rdValid_off", 32'(rdValid), 32'd0);
        check("basic_empty", 32'(empty), 32'd1);

        // Full / overflow
        for (int i = 1; i <= 17; i++) begin
            wrReq  = 1'b1;
            wrData = 21'(i);
            tick();
            if (i == 15) check("fill_notfull", 32'(full), 32'd0);
            if (i == 16) begin
                check("fill_full", 32'(full), 32'd1);
                check("fill_ovf_pre", 32'(overflow), 32'd0);
            end
        end
        wrReq = 1'b0;
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        wDone = 1'b1;
        tick();
        wDone = 1'b0;
        check("ovf_batchCount", 32'(batchCount), 32'd16);
        for (int i = 1; i <= 16; i++) begin
            rdReq = 1'b1;
            tick();
            check("drain_rdData", 32'(rdData), 32'(i));
        end
        rdReq = 1'b0;
        tick();
        check("drain_empty", 32'(empty), 32'd1);
        check("ovf_sticky", 32'(overflow), 32'd1);
        clrErr = 1'b1;
        tick();
        clrErr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);

        // Wrap and concurrency at occupancy 8
        for (int i = 0; i < 8; i++) begin
            wrReq  = 1'b1;
            wrData = 21'(100 + i);
            tick();
        end
        check("wrap_pre_count", 32'(count), 32'd8);
        for (int k = 0; k < 40; k++) begin
            wrReq  = 1'b1;
            rdReq  = 1'b1;
            wrData = 21'(108 + k);
            tick();
            check("wrap_count", 32'(count), 32'd8);
            check("wrap_full", 32'(full), 32'd0);
            check("wrap_empty", 32'(empty), 32'd0);
            check("wrap_rdData", 32'(rdData), 32'(100 + k));
        end
        wrReq = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("wrap_tail", 32'(rdData), 32'(140 + k));
        end
        rdReq = 1'b0;
        wDone = 1'b1;
        tick();
        wDone = 1'b0;
        tick();
        check("wrap_empty_end", 32'(empty), 32'd1);

        // Edge strobes
        rdReq = 1'b1;
        tick();
        rdReq = 1'b0;
        check("rdEmpty_valid", 32'(rdValid), 32'd0);
        check("rdEmpty_hold", 32'(rdData), 32'd147);
        wDone = 1'b1;
        tick();
        wDone = 1'b0;
        check("idleDone_bd", 32'(batchDone), 32'd1);
        check("idleDone_cnt", 32'(batchCount), 32'd0);
        for (int i = 0; i < 4; i++) begin
            wrReq  = 1'b1;
            wrData = 21'(200 + i);
            tick();
        end
        wrData = 21'd204;
        wDone  = 1'b1;
        tick();
        wrReq = 1'b0;
        wDone = 1'b0;
        check("sameCyc_bd", 32'(batchDone), 32'd1);
        check("sameCyc_cnt", 32'(batchCount), 32'd5);
        check("sameCyc_count", 32'(count), 32'd5);

        // Reset mid-batch
        for (int i = 0; i < 6; i++) begin
            wrReq  = 1'b1;
            wrData = 21'(300 + i);
            tick();
        end
        wrReq = 1'b0;
        check("mid_count", 32'(count), 32'd11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_bd", 32'(batchDone), 32'd0);
        tick();
        check("mid_rst_bd2", 32'(batchDone), 32'd0);
        for (int i = 0; i < 2; i++) begin
            wrReq  = 1'b1;
            wrData = 21'(400 + i);
            tick();
        end
        wrReq = 1'b0;
        wDone = 1'b1;
        tick();
        wDone = 1'b0;
        check("post_bd", 32'(batchDone), 32'd1);
        check("post_cnt", 32'(batchCount), 32'd2);
        rdReq = 1'b1;
        tick();
        rdReq = 1'b0;
        check("post_rdData", 32'(rdData), 32'd400);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
